sa2_cache_controller: RTL and testbench
=======================================

Name: sa2_cache_controller

Overview:
- 2-way set-associative, write-back, write-allocate data cache controller with true-LRU replacement.
- Generalises the byte-wide direct-mapped controller: 32-bit word accesses with byte enables, a parametrised index and line size, and a whole-cache flush (write back dirty lines, then invalidate).
- Sits between the core load/store unit and the line-granular memory request/response channel (DDR FIFO side).

Parameters:
- ADDR_W, 27, byte address width.
- INDEX_W, 9, set index bits; sets = 2**INDEX_W.
- OFFSET_W, 4, line offset bits; LINE_W = 8*2**OFFSET_W (128 by default); OFFSET_W >= 2.
- TAG_W, ADDR_W-INDEX_W-OFFSET_W (14 by default), derived; do not override.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller accepts a request this cycle.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored (word-aligned).
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  one-cycle pulse: read data valid or write complete.
- rsp_rdata  out  32  read word; 0 when rsp_valid is low.
- flush_valid  in  1  start a flush; sampled only in IDLE.
- flush_done  out  1  one-cycle pulse when a flush completes.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_cmd  out  1  1 = read line, 0 = write line.
- mem_req_addr  out  ADDR_W-OFFSET_W  line address {tag,index}.
- mem_req_data  out  LINE_W  write-back line data.
- mem_rsp_valid  in  1  refill line valid (always accepted, no ready).
- mem_rsp_data  in  LINE_W  refill line.

Behaviour:
- Storage:
  - Per way: one synchronous-read BRAM for data (LINE_W) and one for tag (TAG_W).
  - Valid[2][sets], dirty[2][sets] and lru[sets] live in flops; all are cleared by rstn.
- Reset: state = IDLE; req_ready = 1; rsp_valid, flush_done, mem_req_valid = 0; all data outputs 0.
- Request capture: a request is accepted when req_valid && req_ready. addr, we, wdata and be are latched in that cycle. Tag/data RAMs are read at the request's index in the same cycle.
- States: IDLE, COMPARE, WB, ALLOC, REFILL, FL_RD, FL_CHK, FL_WB.
- IDLE:
  - req_ready = 1.
  - flush_valid has priority: if flush_valid is high, go to FL_RD with counter = 0 and req_ready = 0 that cycle.
  - Otherwise an accepted request goes to COMPARE.
- COMPARE:
  - hit_w = valid[w] && tag_rd[w] == tag.
  - Read hit: rsp_valid = 1 and rsp_rdata = word addr[OFFSET_W-1:2] of the hit line. Hit latency is 1 cycle after accept.
  - Write hit: merge the enabled bytes into the hit line, write the data RAM, set dirty[w], pulse rsp_valid with rdata = 0.
  - On any hit: lru[idx] = ~hit_way (points at the not-recently-used way); next state IDLE.
  - Miss, victim selection: invalid way0, else invalid way1, else the lru way.
  - Miss, victim valid && dirty: go to WB.
  - Miss, otherwise: go to ALLOC.
- WB: mem_req_valid = 1, cmd = 0, addr = {victim tag, idx}, data = victim line. Hold all fields stable until mem_req_ready, then go to ALLOC.
- ALLOC: mem_req_valid = 1, cmd = 1, addr = {tag, idx}. On mem_req_ready go to REFILL.
- REFILL:
  - On mem_rsp_valid: write mem_rsp_data to the victim data RAM and the new tag to the tag RAM; set valid; clear dirty.
  - Then re-read the index and return to COMPARE, which now hits (miss service ends with the normal hit response).
  - mem_rsp_valid in any other state is ignored.
- Flush:
  - FL_RD reads set counter s.
  - FL_CHK, for way 0 then way 1: if valid && dirty, go to FL_WB and issue a write of {tag,s} with its line, holding until ready.
  - After both ways: clear valid/dirty for set s.
  - If s == sets-1: pulse flush_done, go to IDLE. Otherwise s+1 and go to FL_RD.
- Handshake rule: mem_req_valid, once raised, stays high with stable cmd/addr/data until mem_req_ready.
- Edge cases:
  - Back-to-back requests: a new request is accepted only in IDLE, so peak throughput is one access per 2 cycles.
  - req_be = 0 on a write: treated as a hit/miss normally, line contents unchanged, dirty is still set.
  - rstn asserted mid-miss or mid-flush: abort immediately. Cache contents become invalid (valid cleared); any late mem_rsp is ignored.

Test Plan:
- Reset, then read 0x0000100 → ALLOC addr 0x000010 cmd 1. Refill with word0 = 0xDEADBEEF → rsp_rdata 0xDEADBEEF. Repeat read → rsp_valid exactly 1 cycle after accept with no mem traffic.
- Write 0x0000104, be = 4'b0011, wdata 0x12345678 (line already cached) → re-read gives 0x????5678 with upper bytes preserved; dirty set.
- Set 0x10 conflict: access tags 0, 1, then 2 (0x0000100, 0x0002100, 0x0004100), with tag 0 dirty and tag 1 most recently used → tag 0 evicted via WB addr 0x000010 carrying the dirty data, then ALLOC 0x000410.
- mem_req_ready held low 5 cycles in WB → mem_req_valid, addr and data stable for all 5 cycles; single transfer.
- Flush with two dirty lines (sets 0x10, 0x1FF) → exactly 2 write-backs in set order, flush_done after set 511, then every read misses.
- rstn pulsed low while in REFILL, then mem_rsp_valid arrives → ignored; outputs stay at reset values; the next read of the same address misses.

Source files
------------

// File: rtl/sa2_cache_controller.sv
// sa2_cache_controller: 2-way set-associative write-back/write-allocate data cache with true-LRU
// replacement, byte-enabled word access and whole-cache flush, in front of a line-granular memory port.
module sa2_cache_controller #(
    parameter int ADDR_W   = 27,
    parameter int INDEX_W  = 9,
    parameter int OFFSET_W = 4,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic                       req_we,
    input  logic [31:0]                req_wdata,
    input  logic [3:0]                 req_be,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    input  logic                       flush_valid,
    output logic                       flush_done,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_cmd,
    output logic [ADDR_W-OFFSET_W-1:0] mem_req_addr,
    output logic [8*(2**OFFSET_W)-1:0] mem_req_data,
    input  logic                       mem_rsp_valid,
    input  logic [8*(2**OFFSET_W)-1:0] mem_rsp_data
);
    localparam int LINE_W = 8 * (2 ** OFFSET_W);
    localparam int SETS   = 2 ** INDEX_W;

    typedef enum logic [2:0] {IDLE, COMPARE, WB, ALLOC, REFILL, FL_RD, FL_CHK, FL_WB} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               victim_q, fway_q;
    logic [INDEX_W-1:0] set_q;
    logic [1:0][SETS-1:0] valid, dirty;
    logic [SETS-1:0]    lru;
    logic [LINE_W-1:0]  data_ram [2][SETS];
    logic [TAG_W-1:0]   tag_ram  [2][SETS];
    logic [LINE_W-1:0]  data_rd  [2];
    logic [TAG_W-1:0]   tag_rd   [2];

    logic [INDEX_W-1:0]  idx, rd_idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] woff;
    logic                hit0, hit1, hit, hit_way, victim, rd_en, refill, wr_hit, fd, set_end, last_set;
    logic [1:0]          ram_we;
    logic [LINE_W-1:0]   hit_line, wr_line, ram_wdata;
    logic [31:0]         cur_word, new_word;

    assign idx      = addr_q[OFFSET_W +: INDEX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign woff     = addr_q[OFFSET_W-1:0] & ~OFFSET_W'(3);
    assign hit0     = valid[0][idx] && tag_rd[0] == tag;
    assign hit1     = valid[1][idx] && tag_rd[1] == tag;
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign victim   = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
    assign hit_line = data_rd[hit_way];
    assign cur_word = hit_line[{woff, 3'b000} +: 32];
    assign rd_en    = state == IDLE || state == FL_RD;
    assign rd_idx   = state == FL_RD ? set_q : req_addr[OFFSET_W +: INDEX_W];
    assign refill   = state == REFILL && mem_rsp_valid;
    assign wr_hit   = state == COMPARE && hit && we_q;
    assign ram_we   = {(refill && victim_q) || (wr_hit && hit_way), (refill && !victim_q) || (wr_hit && !hit_way)};
    assign ram_wdata = refill ? mem_rsp_data : wr_line;
    assign fd       = valid[fway_q][set_q] && dirty[fway_q][set_q];
    assign set_end  = fway_q && ((state == FL_CHK && !fd) || (state == FL_WB && mem_req_ready));
    assign last_set = &set_q;

    always_comb begin
        new_word = cur_word;
        for (int i = 0; i < 4; i++)
            if (be_q[i]) new_word[8*i +: 8] = wdata_q[8*i +: 8];
        wr_line = hit_line;
        wr_line[{woff, 3'b000} +: 32] = new_word;
    end

    // Refill also loads the read registers so COMPARE sees the new line without a RAM re-read cycle.
    always_ff @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (ram_we[w]) begin
                data_ram[w][idx] <= ram_wdata;
                tag_ram[w][idx]  <= tag;
            end
            if (rd_en) begin
                data_rd[w] <= data_ram[w][rd_idx];
                tag_rd[w]  <= tag_ram[w][rd_idx];
            end else if (refill && victim_q == 1'(w)) begin
                data_rd[w] <= mem_rsp_data;
                tag_rd[w]  <= tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = flush_valid ? FL_RD : req_valid ? COMPARE : IDLE;
            COMPARE: state_nx = hit ? IDLE : (valid[victim][idx] && dirty[victim][idx]) ? WB : ALLOC;
            WB:      state_nx = mem_req_ready ? ALLOC : WB;
            ALLOC:   state_nx = mem_req_ready ? REFILL : ALLOC;
            REFILL:  state_nx = mem_rsp_valid ? COMPARE : REFILL;
            FL_RD:   state_nx = FL_CHK;
            FL_CHK:  state_nx = fd ? FL_WB : !fway_q ? FL_CHK : last_set ? IDLE : FL_RD;
            FL_WB:   state_nx = !mem_req_ready ? FL_WB : !fway_q ? FL_CHK : last_set ? IDLE : FL_RD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = state == IDLE && !flush_valid;
        rsp_valid     = state == COMPARE && hit;
        rsp_rdata     = rsp_valid && !we_q ? cur_word : '0;
        flush_done    = set_end && last_set;
        mem_req_valid = state inside {WB, ALLOC, FL_WB};
        mem_req_cmd   = state == ALLOC;
        mem_req_addr  = state == WB    ? {tag_rd[victim_q], idx} :
                        state == ALLOC ? {tag, idx} :
                        state == FL_WB ? {tag_rd[fway_q], set_q} : '0;
        mem_req_data  = state == WB    ? data_rd[victim_q] :
                        state == FL_WB ? data_rd[fway_q] : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            victim_q <= 1'b0;
            fway_q   <= 1'b0;
            set_q    <= '0;
            valid    <= '0;
            dirty    <= '0;
            lru      <= '0;
        end else begin
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state == COMPARE && !hit) victim_q <= victim;
            if (state == COMPARE && hit) begin
                lru[idx] <= !hit_way;
                if (we_q) dirty[hit_way][idx] <= 1'b1;
            end
            if (refill) begin
                valid[victim_q][idx] <= 1'b1;
                dirty[victim_q][idx] <= 1'b0;
            end
            if (state == IDLE && flush_valid) begin
                set_q  <= '0;
                fway_q <= 1'b0;
            end
            if (!fway_q && ((state == FL_CHK && !fd) || (state == FL_WB && mem_req_ready))) fway_q <= 1'b1;
            if (set_end) begin
                valid[0][set_q] <= 1'b0;
                valid[1][set_q] <= 1'b0;
                dirty[0][set_q] <= 1'b0;
                dirty[1][set_q] <= 1'b0;
                set_q  <= set_q + 1'b1;
                fway_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sa2_cache_controller.sv
// tb_sa2_cache_controller: randomized and directed accesses against a set/way/LRU model
// plus golden word memory; memory side is serviced with random ready and refill delays.
module tb_sa2_cache_controller;
    logic         clk = 0, rstn = 0;
    logic         req_valid = 0, req_we = 0, flush_valid = 0, mem_req_ready = 0, mem_rsp_valid = 0;
    logic [26:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_be = '0;
    logic [127:0] mem_rsp_data = '0;
    logic         req_ready, rsp_valid, flush_done, mem_req_valid, mem_req_cmd;
    logic [31:0]  rsp_rdata;
    logic [22:0]  mem_req_addr;
    logic [127:0] mem_req_data;

    sa2_cache_controller dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .flush_valid(flush_valid), .flush_done(flush_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_cmd(mem_req_cmd),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] gmem [int];
    logic [31:0] mmem [int];
    bit          mv [512][2], md [512][2];
    logic [13:0] mt [512][2];
    bit          ml [512];

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] init_word(int wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] gword(int wa);
        return gmem.exists(wa) ? gmem[wa] : init_word(wa);
    endfunction
    function automatic logic [31:0] mword(int wa);
        return mmem.exists(wa) ? mmem[wa] : init_word(wa);
    endfunction
    function automatic logic [127:0] gline(int la);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = gword(la * 4 + i);
        return r;
    endfunction
    function automatic logic [127:0] mline(int la);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = mword(la * 4 + i);
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 512; s++) begin
            mv[s] = '{0, 0};
            md[s] = '{0, 0};
            ml[s] = 0;
        end
    endtask

    // Handshake stability: a stalled memory request must reappear unchanged.
    logic         p_v = 0, p_r = 0, p_c = 0;
    logic [22:0]  p_a = '0;
    logic [127:0] p_d = '0;
    always @(negedge clk) begin
        if (rstn && p_v && !p_r) begin
            checks++;
            if (!(mem_req_valid && mem_req_cmd == p_c && mem_req_addr == p_a && mem_req_data == p_d)) begin
                errors++;
                $display("FAIL mem_req_hold got v=%b a=%h want a=%h", mem_req_valid, mem_req_addr, p_a);
            end
        end
        p_v = rstn && mem_req_valid;
        p_r = mem_req_ready;
        p_c = mem_req_cmd;
        p_a = mem_req_addr;
        p_d = mem_req_data;
    end

    // One core access: model predicts traffic and response, then the DUT is driven and checked.
    task automatic access(input logic [26:0] a, input bit we, input logic [31:0] wd, input logic [3:0] be,
                          input int stall, output int lat, output int nwb, output int nal,
                          output logic [22:0] wb_a, output logic [127:0] wb_d,
                          output logic [22:0] al_a, output logic [31:0] rd);
        logic [22:0]  la = a[26:4];
        logic [8:0]   idx = la[8:0];
        logic [13:0]  tg = la[22:9];
        int           wa = int'(a[26:2]);
        int           h = -1, v, pend = -1;
        bit           miss, exp_wb = 0, got = 0, rdy;
        logic [22:0]  exp_wba = '0;
        logic [127:0] exp_wbd = '0;
        logic [31:0]  g, exp_rd;
        for (int w = 0; w < 2; w++) if (mv[idx][w] && mt[idx][w] == tg) h = w;
        miss = h < 0;
        if (miss) begin
            v = !mv[idx][0] ? 0 : !mv[idx][1] ? 1 : int'(ml[idx]);
            exp_wb = mv[idx][v] && md[idx][v];
            exp_wba = {mt[idx][v], idx};
            exp_wbd = gline(int'(exp_wba));
            mv[idx][v] = 1; md[idx][v] = 0; mt[idx][v] = tg;
            h = v;
        end
        ml[idx] = !h[0];
        if (we) begin
            g = gword(wa);
            for (int i = 0; i < 4; i++) if (be[i]) g[8*i +: 8] = wd[8*i +: 8];
            gmem[wa] = g;
            md[idx][h] = 1;
        end
        exp_rd = we ? 32'h0 : gword(wa);
        lat = 0; nwb = 0; nal = 0; wb_a = '0; wb_d = '0; al_a = '0; rd = '0;
        chk("req_ready_idle", req_ready, 1);
        req_addr = a; req_we = we; req_wdata = wd; req_be = be; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; req_we = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            mem_rsp_valid = 0;
            if (pend == 0) begin
                mem_rsp_valid = 1;
                mem_rsp_data = mline(int'(al_a));
                pend = -1;
            end else if (pend > 0) pend--;
            if (rsp_valid) begin
                got = 1; lat = cyc; rd = rsp_rdata;
                break;
            end
            if (mem_req_valid) begin
                rdy = (stall > 0 && !mem_req_cmd) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (stall > 0 && !mem_req_cmd) stall--;
                mem_req_ready = rdy;
                if (rdy && !mem_req_cmd) begin
                    nwb++; wb_a = mem_req_addr; wb_d = mem_req_data;
                    for (int i = 0; i < 4; i++) mmem[int'(wb_a) * 4 + i] = wb_d[32*i +: 32];
                end else if (rdy) begin
                    nal++; al_a = mem_req_addr; pend = int'($urandom_range(0, 3));
                end
            end else mem_req_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        mem_req_ready = 0; mem_rsp_valid = 0;
        chk("rsp_seen", got, 1);
        chk("rsp_rdata", rd, exp_rd);
        chk("wb_count", nwb, exp_wb);
        chk("alloc_count", nal, miss);
        if (exp_wb && nwb > 0) begin
            chk("wb_addr", wb_a, exp_wba);
            chk("wb_data", wb_d, exp_wbd);
        end
        if (miss && nal > 0) chk("alloc_addr", al_a, la);
        if (!miss) chk("hit_latency", lat, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_flush(output int n, output logic [22:0] first_a, output logic [22:0] last_a);
        logic [22:0]  qa [$];
        logic [127:0] qd [$];
        int           exp_n;
        bit           done = 0;
        for (int s = 0; s < 512; s++)
            for (int w = 0; w < 2; w++)
                if (mv[s][w] && md[s][w]) begin
                    qa.push_back({mt[s][w], 9'(s)});
                    qd.push_back(gline(int'({mt[s][w], 9'(s)})));
                end
        exp_n = qa.size();
        model_clear();
        n = 0; first_a = '0; last_a = '0;
        flush_valid = 1;
        #1;
        chk("req_ready_flush", req_ready, 0);
        @(posedge clk); #1;
        flush_valid = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            mem_req_ready = mem_req_valid ? ($urandom_range(0, 2) != 0) : 1'b0;
            #1;
            if (mem_req_valid && mem_req_ready) begin
                chk("flush_cmd", mem_req_cmd, 0);
                if (n == 0) first_a = mem_req_addr;
                last_a = mem_req_addr;
                n++;
                for (int i = 0; i < 4; i++) mmem[int'(mem_req_addr) * 4 + i] = mem_req_data[32*i +: 32];
                if (qa.size() > 0) begin
                    chk("flush_wb_addr", mem_req_addr, qa[0]);
                    chk("flush_wb_data", mem_req_data, qd[0]);
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
            end
            if (flush_done) done = 1;
            @(posedge clk); #1;
            if (done) break;
        end
        mem_req_ready = 0;
        chk("flush_done_seen", done, 1);
        chk("flush_wb_count", n, exp_n);
    endtask

    initial begin
        int lat, nwb, nal;
        logic [22:0]  wa_, aa, fa, la_;
        logic [127:0] wd_;
        logic [31:0]  rd;
        logic [26:0]  a;
        logic [8:0]   idxs [4] = '{9'h010, 9'h011, 9'h1FF, 9'h000};
        bit           got;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_mem_req_data", mem_req_data, 0);
        rstn = 1;
        @(posedge clk); #1;

        gmem[32'h40] = 32'hDEADBEEF; mmem[32'h40] = 32'hDEADBEEF;
        gmem[32'h41] = 32'hCAFEBABE; mmem[32'h41] = 32'hCAFEBABE;
        access(27'h0000100, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("d_first_alloc", aa, 23'h000010);
        chk("d_first_rdata", rd, 32'hDEADBEEF);
        access(27'h0000100, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("d_hit_latency", lat, 1);
        chk("d_hit_no_mem", nwb + nal, 0);
        access(27'h0000104, 1, 32'h12345678, 4'b0011, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        access(27'h0000104, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("d_merge_rdata", rd, 32'hCAFE5678);
        access(27'h0002100, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("d_tag1_alloc", aa, 23'h000210);
        access(27'h0004100, 0, 0, 0, 5, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("d_evict_wb_count", nwb, 1);
        chk("d_evict_wb_addr", wa_, 23'h000010);
        chk("d_evict_wb_word0", wd_[31:0], 32'hDEADBEEF);
        chk("d_evict_wb_word1", wd_[63:32], 32'hCAFE5678);
        chk("d_evict_alloc", aa, 23'h000410);

        for (int k = 0; k < 300; k++) begin
            a = {14'($urandom_range(0, 3)), idxs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 0, lat, nwb, nal, wa_, wd_, aa, rd);
        end

        do_flush(nwb, fa, la_);
        access(27'h0000100, 1, 32'hA5A5A5A5, 4'b1111, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        access(27'h0001FF0, 1, 32'h0BADF00D, 4'b0101, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        access(27'h0000300, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        do_flush(nwb, fa, la_);
        chk("d_flush2_count", nwb, 2);
        chk("d_flush2_first", fa, 23'h000010);
        chk("d_flush2_last", la_, 23'h0001FF);
        access(27'h0000100, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("d_post_flush_miss", nal, 1);
        chk("d_post_flush_rdata", rd, 32'hA5A5A5A5);

        req_addr = 27'h0000300; req_we = 0; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; mem_req_ready = 1; got = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_req_valid && mem_req_cmd) begin
                got = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_alloc_seen", got, 1);
        mem_req_ready = 0; rstn = 0;
        model_clear();
        @(posedge clk); #1;
        rstn = 1; mem_rsp_valid = 1; mem_rsp_data = '1;
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        for (int c = 0; c < 3; c++) begin
            chk("abort_req_ready", req_ready, 1);
            chk("abort_rsp_valid", rsp_valid, 0);
            chk("abort_mem_req_valid", mem_req_valid, 0);
            chk("abort_rsp_rdata", rsp_rdata, 0);
            @(posedge clk); #1;
        end
        access(27'h0000300, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("abort_reread_miss", nal, 1);
        access(27'h0000100, 0, 0, 0, 0, lat, nwb, nal, wa_, wd_, aa, rd);
        chk("abort_other_miss", nal, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
